// File: rtl/tdc_hist_pingpong_pkg.sv
// Shared defaults, state encoding and width helper for the ping-pong dToF histogram builder.
package tdc_hist_pingpong_pkg;

    localparam int ADDR_W_DEF    = 6;
    localparam int CNT_W_DEF     = 8;
    localparam int DATA_NUM_DEF  = 2;
    localparam int PIXEL_NUM_DEF = 200;
    localparam int ACQ_NUM_DEF   = 33333;
    localparam int NBINS_DEF     = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        ACCUM     = 2'd1,
        CLEAR_WB  = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdc_hist_pingpong_if.sv
// Hit, read-and-clear and status bundle between the TDC encoder, the histogram builder and the peak stage.
interface tdc_hist_pingpong_if
    import tdc_hist_pingpong_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              his_num;
    logic              frame_done;
    logic              frame_sat;
    logic              overrun;
    logic              busy;

    modport master (
        output wr_en, addr, rd_en, rd_addr,
        input  rd_data, rd_valid, his_num, frame_done, frame_sat, overrun, busy
    );

    modport slave (
        input  wr_en, addr, rd_en, rd_addr,
        output rd_data, rd_valid, his_num, frame_done, frame_sat, overrun, busy
    );
endinterface

// File: rtl/tdc_hist_pingpong_hist_bank_rf.sv
// Two-bank histogram register file: saturating increment, read-and-clear and sweep-clear ports.
module tdc_hist_pingpong_hist_bank_rf
    import tdc_hist_pingpong_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              inc_en_i,
    input  logic              inc_bank_i,
    input  logic [ADDR_W-1:0] inc_addr_i,
    output logic              inc_sat_o,
    input  logic              rd_en_i,
    input  logic              rd_bank_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [CNT_W-1:0]  rd_data_o,
    input  logic              clr_en_i,
    input  logic [1:0]        clr_mask_i,
    input  logic [ADDR_W-1:0] clr_idx_i
);
    localparam int NBINS = 1 << ADDR_W;

    logic [CNT_W-1:0] mem_q [2][NBINS];
    logic [CNT_W-1:0] inc_old;

    assign inc_old   = mem_q[inc_bank_i][inc_addr_i];
    assign inc_sat_o = inc_en_i && (inc_old == '1);
    assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

    // NOTE: the array has no reset; the CLEAR_ALL sweep zeroes it before any hit or read is accepted.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking writes to the same entry resolve last-wins, so the clear ports dominate.
        if (inc_en_i && !inc_sat_o) mem_q[inc_bank_i][inc_addr_i] <= inc_old + CNT_W'(1);
        if (rd_en_i)                mem_q[rd_bank_i][rd_addr_i]   <= '0;
        if (clr_en_i && clr_mask_i[0]) mem_q[1'b0][clr_idx_i] <= '0;
        if (clr_en_i && clr_mask_i[1]) mem_q[1'b1][clr_idx_i] <= '0;
    end
endmodule

// File: rtl/tdc_hist_pingpong.sv
// Ping-pong histogram builder: FSM, nested event counters, drain tracking and frame status flags.
module tdc_hist_pingpong
    import tdc_hist_pingpong_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int ACQ_NUM   = ACQ_NUM_DEF
) (
    input logic                clk,
    input logic                res,
    tdc_hist_pingpong_if.slave bus
);
    localparam int NBINS = 1 << ADDR_W;
    localparam int IN_W  = cnt_width(DATA_NUM);
    localparam int PIX_W = cnt_width(PIXEL_NUM);
    localparam int ACQ_W = cnt_width(ACQ_NUM);
    localparam int DR_W  = cnt_width(NBINS + 1);

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(DATA_NUM - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
    localparam logic [DR_W-1:0]  DRAINED  = DR_W'(NBINS);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [IN_W-1:0]    in_cnt_q, in_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d;
    logic [DR_W-1:0]    drain_q, drain_d, drain_nxt;
    logic               his_q, his_d;
    logic               done_q, done_d;
    logic               fsat_q, fsat_d;
    logic               ovr_q, ovr_d;
    logic               spend_q, spend_d;
    logic               rdv_q, rdv_d;
    logic [CNT_W-1:0]   rdata_q, rdata_d;

    logic               wr_acc, rd_acc, last_hit, inc_sat, clr_en;
    logic [1:0]         clr_mask;
    logic [CNT_W-1:0]   rf_rd_data;

    assign wr_acc    = bus.wr_en && (state_q == ACCUM);
    assign rd_acc    = bus.rd_en && (state_q != CLEAR_ALL);
    assign last_hit  = wr_acc && (in_cnt_q == IN_LAST) && (pix_cnt_q == PIX_LAST)
                       && (acq_cnt_q == ACQ_LAST);
    // A read on the swap edge already counts toward the drain check of that same swap.
    assign drain_nxt = (rd_acc && (drain_q != DRAINED)) ? drain_q + DR_W'(1) : drain_q;
    assign clr_en    = (state_q != ACCUM);
    assign clr_mask  = (state_q == CLEAR_ALL) ? 2'b11 : (his_q ? 2'b10 : 2'b01);

    tdc_hist_pingpong_hist_bank_rf #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rf (
        .clk        (clk),
        .inc_en_i   (wr_acc),
        .inc_bank_i (his_q),
        .inc_addr_i (bus.addr),
        .inc_sat_o  (inc_sat),
        .rd_en_i    (rd_acc),
        .rd_bank_i  (~his_q),
        .rd_addr_i  (bus.rd_addr),
        .rd_data_o  (rf_rd_data),
        .clr_en_i   (clr_en),
        .clr_mask_i (clr_mask),
        .clr_idx_i  (idx_q)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= CLEAR_ALL;
            idx_q     <= '0;
            in_cnt_q  <= '0;
            pix_cnt_q <= '0;
            acq_cnt_q <= '0;
            drain_q   <= '0;
            his_q     <= 1'b0;
            done_q    <= 1'b0;
            fsat_q    <= 1'b0;
            ovr_q     <= 1'b0;
            spend_q   <= 1'b0;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_cnt_q  <= in_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            acq_cnt_q <= acq_cnt_d;
            drain_q   <= drain_d;
            his_q     <= his_d;
            done_q    <= done_d;
            fsat_q    <= fsat_d;
            ovr_q     <= ovr_d;
            spend_q   <= spend_d;
            rdv_q     <= rdv_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        in_cnt_d  = in_cnt_q;
        pix_cnt_d = pix_cnt_q;
        acq_cnt_d = acq_cnt_q;
        drain_d   = drain_nxt;
        his_d     = his_q;
        done_d    = 1'b0;
        fsat_d    = fsat_q;
        ovr_d     = ovr_q;
        spend_d   = spend_q;
        rdv_d     = rd_acc;
        rdata_d   = rd_acc ? rf_rd_data : rdata_q;

        unique case (state_q)
            CLEAR_ALL, CLEAR_WB: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == '1) state_d = ACCUM;
            end
            ACCUM: begin
                if (wr_acc) begin
                    spend_d = spend_q | inc_sat;
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            acq_cnt_d = (acq_cnt_q == ACQ_LAST) ? '0 : acq_cnt_q + ACQ_W'(1);
                        end else begin
                            pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + IN_W'(1);
                    end
                    if (last_hit) begin
                        his_d   = ~his_q;
                        fsat_d  = spend_q | inc_sat;
                        spend_d = 1'b0;
                        done_d  = 1'b1;
                        drain_d = '0;
                        if (drain_nxt != DRAINED) begin
                            ovr_d   = 1'b1;
                            state_d = CLEAR_WB;
                        end
                    end
                end
            end
            default: state_d = CLEAR_ALL;
        endcase
    end

    assign bus.rd_data    = rdata_q;
    assign bus.rd_valid   = rdv_q;
    assign bus.his_num    = his_q;
    assign bus.frame_done = done_q;
    assign bus.frame_sat  = fsat_q;
    assign bus.overrun    = ovr_q;
    // Gated by res so every output reads 0 while reset is held, even though the state is CLEAR_ALL.
    assign bus.busy       = (state_q != ACCUM) && !res;
endmodule

// File: tb/tb_tdc_hist_pingpong.sv
// Directed plus randomized bench: two builders (CNT_W=4 and CNT_W=2) share stimulus and an array-based model.
module tb_tdc_hist_pingpong;
    localparam int NB  = 8;
    localparam int HPF = 8;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    tdc_hist_pingpong_if #(.ADDR_W(3), .CNT_W(4)) if_a ();
    tdc_hist_pingpong_if #(.ADDR_W(3), .CNT_W(2)) if_b ();

    tdc_hist_pingpong #(.ADDR_W(3), .CNT_W(4), .DATA_NUM(2), .PIXEL_NUM(2), .ACQ_NUM(2))
        dut_a (.clk(clk), .res(res), .bus(if_a));
    tdc_hist_pingpong #(.ADDR_W(3), .CNT_W(2), .DATA_NUM(2), .PIXEL_NUM(2), .ACQ_NUM(2))
        dut_b (.clk(clk), .res(res), .bus(if_b));

    int n_assert = 0;
    int n_fail   = 0;

    // Model: per-DUT bank contents, plus frame bookkeeping shared by both.
    int bank [2][2][NB];
    int maxv [2];
    int m_clear_left, m_his, m_hits, m_drain;
    bit m_in_clear_all, m_done, m_rdv, m_ovr;
    int m_rdata [2];
    bit m_spend [2];
    bit m_fsat  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        maxv[0] = (1 << 4) - 1;
        maxv[1] = (1 << 2) - 1;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NB; i++) bank[k][b][i] = 0;
            m_rdata[k] = 0;
            m_spend[k] = 1'b0;
            m_fsat[k]  = 1'b0;
        end
        m_clear_left   = NB;
        m_in_clear_all = 1'b1;
        m_his = 0; m_hits = 0; m_drain = 0;
        m_done = 1'b0; m_rdv = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input bit we, input int a, input bit re, input int ra);
        bit busy_pre;
        busy_pre = (m_clear_left > 0);
        m_done = 1'b0;
        m_rdv  = re && !m_in_clear_all;
        if (m_rdv) begin
            for (int k = 0; k < 2; k++) begin
                m_rdata[k] = bank[k][1-m_his][ra];
                bank[k][1-m_his][ra] = 0;
            end
            if (m_drain < NB) m_drain++;
        end
        if (busy_pre) begin
            m_clear_left--;
            if (m_clear_left == 0) m_in_clear_all = 1'b0;
        end else if (we) begin
            for (int k = 0; k < 2; k++) begin
                if (bank[k][m_his][a] == maxv[k]) m_spend[k] = 1'b1;
                else bank[k][m_his][a]++;
            end
            m_hits++;
            if (m_hits == HPF) begin
                m_hits = 0;
                m_his  = 1 - m_his;
                for (int k = 0; k < 2; k++) begin
                    m_fsat[k]  = m_spend[k];
                    m_spend[k] = 1'b0;
                end
                m_done = 1'b1;
                if (m_drain != NB) begin
                    m_ovr = 1'b1;
                    m_clear_left = NB;
                    for (int k = 0; k < 2; k++)
                        for (int i = 0; i < NB; i++) bank[k][m_his][i] = 0;
                end
                m_drain = 0;
            end
        end
    endtask

    task automatic check_dut(input string p, input int k, input bit in_rst,
                             input logic [31:0] busy, input logic [31:0] his,
                             input logic [31:0] done, input logic [31:0] rdv,
                             input logic [31:0] rd, input logic [31:0] fsat,
                             input logic [31:0] ovr);
        chk({p, ".busy"},       busy, 32'((!in_rst) && (m_clear_left > 0)));
        chk({p, ".his_num"},    his,  32'(m_his));
        chk({p, ".frame_done"}, done, 32'(m_done));
        chk({p, ".rd_valid"},   rdv,  32'(m_rdv));
        chk({p, ".rd_data"},    rd,   32'(m_rdata[k]));
        chk({p, ".frame_sat"},  fsat, 32'(m_fsat[k]));
        chk({p, ".overrun"},    ovr,  32'(m_ovr));
    endtask

    task automatic check_all(input bit in_rst);
        check_dut("A", 0, in_rst, 32'(if_a.busy), 32'(if_a.his_num), 32'(if_a.frame_done),
                  32'(if_a.rd_valid), 32'(if_a.rd_data), 32'(if_a.frame_sat), 32'(if_a.overrun));
        check_dut("B", 1, in_rst, 32'(if_b.busy), 32'(if_b.his_num), 32'(if_b.frame_done),
                  32'(if_b.rd_valid), 32'(if_b.rd_data), 32'(if_b.frame_sat), 32'(if_b.overrun));
    endtask

    task automatic drive(input bit we, input logic [2:0] a, input bit re, input logic [2:0] ra);
        if_a.wr_en = we; if_a.addr = a; if_a.rd_en = re; if_a.rd_addr = ra;
        if_b.wr_en = we; if_b.addr = a; if_b.rd_en = re; if_b.rd_addr = ra;
    endtask

    task automatic cycle(input bit we, input logic [2:0] a, input bit re, input logic [2:0] ra);
        drive(we, a, re, ra);
        @(posedge clk);
        model_step(we, int'(a), re, int'(ra));
        #1 check_all(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    function automatic logic [2:0] raddr();
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        // Reset held for three edges, then released between edges.
        drive(1'b0, 3'd0, 1'b0, 3'd0);
        res = 1'b1;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1 check_all(1'b1);
        end
        @(negedge clk);
        res = 1'b0;
        #1 check_all(1'b0);
        idle(8);
        chk("t1_busy_end", 32'(if_a.busy), 32'd0);

        // One full frame into bin 3, then read-and-clear it twice.
        for (int i = 0; i < HPF; i++) cycle(1'b1, 3'd3, 1'b0, 3'd0);
        chk("t2_done", 32'(if_a.frame_done), 32'd1);
        chk("t2_his",  32'(if_a.his_num),    32'd1);
        cycle(1'b0, 3'd0, 1'b1, 3'd3);
        chk("t2_rd_a",   32'(if_a.rd_data),  32'd8);
        chk("t2_rd_b",   32'(if_b.rd_data),  32'd3);
        chk("t2_rdv",    32'(if_a.rd_valid), 32'd1);
        cycle(1'b0, 3'd0, 1'b1, 3'd3);
        chk("t2_reread", 32'(if_a.rd_data),  32'd0);
        idle(6);

        // Saturation on the narrow builder, then a spread frame that does not saturate.
        for (int i = 0; i < HPF; i++) cycle(1'b1, 3'd5, 1'b0, 3'd0);
        chk("t3_sat_b", 32'(if_b.frame_sat), 32'd1);
        chk("t3_sat_a", 32'(if_a.frame_sat), 32'd0);
        cycle(1'b0, 3'd0, 1'b1, 3'd5);
        chk("t3_rd_b", 32'(if_b.rd_data), 32'd3);
        chk("t3_rd_a", 32'(if_a.rd_data), 32'd8);
        idle(7);
        for (int i = 0; i < HPF; i++) cycle(1'b1, 3'(i), 1'b0, 3'd0);
        chk("t3_sat_clear_b", 32'(if_b.frame_sat), 32'd0);
        idle(8);

        // Asynchronous reset in the middle of a cycle, five hits into a frame.
        for (int i = 0; i < 5; i++) cycle(1'b1, raddr(), 1'b0, 3'd0);
        #2 res = 1'b1;
        #1 model_reset();
        check_all(1'b1);
        @(negedge clk);
        res = 1'b0;
        #1 check_all(1'b0);
        idle(8);
        for (int i = 0; i < NB; i++) begin
            cycle(1'b0, 3'd0, 1'b1, 3'(i));
            chk("t6_zero", 32'(if_a.rd_data), 32'd0);
        end

        // Fully drained read bank: swap without overrun, hit on the very next cycle.
        for (int i = 0; i < HPF; i++) cycle(1'b1, raddr(), 1'b0, 3'd0);
        chk("t4_ovr",  32'(if_a.overrun), 32'd0);
        chk("t4_busy", 32'(if_a.busy),    32'd0);
        cycle(1'b1, 3'd6, 1'b0, 3'd0);

        // Partial drain: overrun, hits dropped during the clear, reads still served.
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b1, 3'(i));
        for (int i = 0; i < HPF - 1; i++) cycle(1'b1, raddr(), 1'b0, 3'd0);
        chk("t5_ovr",  32'(if_a.overrun), 32'd1);
        chk("t5_busy", 32'(if_a.busy),    32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, raddr(), 1'b1, 3'(i));
        for (int i = 3; i < NB; i++) cycle(1'b0, 3'd0, 1'b1, 3'(i));
        chk("t5_busy_end",   32'(if_a.busy),    32'd0);
        chk("t5_ovr_sticky", 32'(if_a.overrun), 32'd1);
        for (int i = 0; i < HPF; i++) cycle(1'b1, raddr(), 1'b0, 3'd0);
        for (int i = 0; i < NB; i++) cycle(1'b0, 3'd0, 1'b1, 3'(i));

        // Random mix of hits and reads, including reads on swap edges and during clears.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), raddr(), ($urandom_range(0, 3) == 0), raddr());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
